// File: rtl/cpu_mul_seq_assembler_if.sv
// Start/done handshake bundle for the iterative 32x32 multiply unit.
interface cpu_mul_seq_assembler_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, op, src1, src2,
    input  busy, done, result
  );

  modport slave (
    input  start, op, src1, src2,
    output busy, done, result
  );
endinterface

// File: rtl/cpu_mul_seq_assembler.sv
// Iterative 32x32 multiplier built on one registered 16x16 unsigned multiplier.
// Optional macro CPU_MUL_SEQ_ZERO_SKIP_EN shortcuts zero operands to an early done.
module cpu_mul_seq_assembler #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  cpu_mul_seq_assembler_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StFix, StZero} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  k_q, k_d;
  logic        drn_q, drn_d;
  logic [63:0] acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Multiplier pipeline: product, shift tag (0, <<16, <<32) and valid per stage.
  logic [MUL_LAT-1:0][31:0] pp_q, pp_d;
  logic [MUL_LAT-1:0][1:0]  sh_q, sh_d;
  logic [MUL_LAT-1:0]       vld_q, vld_d;

  logic        accept;
  logic [15:0] a_half, b_half;
  logic [1:0]  last_k;
  logic [63:0] acc_add, acc_sum;
  logic [31:0] corr_a, corr_b, hi_fix, res_sel;

  always_comb begin
    accept = bus.start && ((state_q == StIdle) || (state_q == StFix));
    last_k = (op_q == 2'b00) ? 2'd2 : 2'd3;

    // Issue order: aL*bL, aL*bH, aH*bL, aH*bH.
    a_half = k_q[1] ? a_q[31:16] : a_q[15:0];
    b_half = k_q[0] ? b_q[31:16] : b_q[15:0];

    pp_d[0]  = 32'(a_half) * 32'(b_half);
    vld_d[0] = (state_q == StIssue);
    case (k_q)
      2'd0:    sh_d[0] = 2'd0;
      2'd3:    sh_d[0] = 2'd2;
      default: sh_d[0] = 2'd1;
    endcase
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      pp_d[i]  = pp_q[i-1];
      sh_d[i]  = sh_q[i-1];
      vld_d[i] = vld_q[i-1];
    end

    acc_add = vld_q[MUL_LAT-1] ?
              ({32'd0, pp_q[MUL_LAT-1]} << {sh_q[MUL_LAT-1], 4'b0000}) : 64'd0;
    acc_sum = acc_q + acc_add;

    corr_a  = (op_q[1] && a_q[31]) ? b_q : 32'd0;
    corr_b  = ((op_q == 2'b11) && b_q[31]) ? a_q : 32'd0;
    hi_fix  = acc_sum[63:32] - corr_a - corr_b;
    res_sel = (op_q == 2'b00) ? acc_sum[31:0] : hi_fix;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    k_d      = k_q;
    drn_d    = drn_q;
    acc_d    = acc_sum;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      StIdle: ;
      StIssue: begin
        k_d = k_q + 2'd1;
        if (k_q == last_k) begin
          state_d = StDrain;
          drn_d   = 1'(MUL_LAT - 1);
        end
      end
      StDrain: begin
        if (drn_q == 1'b0) begin
          state_d  = StFix;
          done_d   = 1'b1;
          result_d = res_sel;
        end else begin
          drn_d = drn_q - 1'b1;
        end
      end
      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      StZero: begin
        state_d  = StFix;
        done_d   = 1'b1;
        result_d = 32'd0;
      end
      default: state_d = StIdle;
    endcase

    // A new request may be taken in the done cycle, overriding the return to idle.
    if (accept) begin
      a_d    = bus.src1;
      b_d    = bus.src2;
      op_d   = bus.op;
      k_d    = 2'd0;
      acc_d  = 64'd0;
      busy_d = 1'b1;
`ifdef CPU_MUL_SEQ_ZERO_SKIP_EN
      state_d = ((bus.src1 == 32'd0) || (bus.src2 == 32'd0)) ? StZero : StIssue;
`else
      state_d = StIssue;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      k_q      <= '0;
      drn_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      pp_q     <= '0;
      sh_q     <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      k_q      <= k_d;
      drn_q    <= drn_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      pp_q     <= pp_d;
      sh_q     <= sh_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_cpu_mul_seq_assembler.sv
// Scoreboard bench for cpu_mul_seq_assembler: expected words and latencies queued at launch.
module tb_cpu_mul_seq_assembler;

  logic clk;
  logic reset_n;

  cpu_mul_seq_assembler_if bus_if ();

  cpu_mul_seq_assembler #(.MUL_LAT(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = op[1] ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef CPU_MUL_SEQ_ZERO_SKIP_EN
    if (a == 32'd0 || b == 32'd0) return 2;
`endif
    return (op == 2'b00) ? 5 : 6;
  endfunction

  // Drive a request just after a falling edge; the next rising edge samples it.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push);
    exp_t e;
    bus_if.op    = op;
    bus_if.src1  = a;
    bus_if.src2  = b;
    bus_if.start = 1'b1;
    if (push) begin
      e.res = model(op, a, b);
      e.lat = exp_lat(op, a, b);
      sb_q.push_back(e);
    end
  endtask

  // Follow one accepted request to done; optionally launch the next one in the done cycle.
  task automatic wait_done(input string name, input bit chain, input logic [1:0] nop,
                           input logic [31:0] na, input logic [31:0] nb);
    exp_t e;
    bit   seen;
    bit   busy_ok;
    seen    = 1'b0;
    busy_ok = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus_if.start = 1'b0;
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
      if (bus_if.done === 1'b1) begin
        seen = 1'b1;
        e = sb_q.pop_front();
        n_cmp++;
        if (bus_if.result !== e.res) begin
          n_err++;
          $display("FAIL %s result: got %h want %h", name, bus_if.result, e.res);
        end
        n_cmp++;
        if (cyc != e.lat) begin
          n_err++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
        end
        n_cmp++;
        if (!busy_ok) begin
          n_err++;
          $display("FAIL %s busy: got low before done want high cycles 1..%0d", name, cyc);
        end
        if (chain) launch(nop, na, nb, 1'b1);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got no done want done within 20 cycles", name);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      bus_if.start = 1'b0;
    end else if (!chain) begin
      @(negedge clk);
      n_cmp++;
      if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
        n_err++;
        $display("FAIL %s after_done: got done=%b busy=%b want 0/0", name, bus_if.done,
                 bus_if.busy);
      end
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b result=%h want 0/0/0", bus_if.busy,
               bus_if.done, bus_if.result);
    end
  endtask

  task automatic test_mul_ops();
    launch(2'b00, 32'h0001_2345, 32'h0000_0010, 1'b1); wait_done("mul_basic", 0, 0, 0, 0);
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("mulxuu_ones", 0, 0, 0, 0);
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("mul_ones", 0, 0, 0, 0);
    launch(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1); wait_done("mulxss_neg1", 0, 0, 0, 0);
    launch(2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1); wait_done("mulxss_min", 0, 0, 0, 0);
    launch(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done("mulxsu_neg", 0, 0, 0, 0);
    launch(2'b10, 32'h0000_0002, 32'h8000_0000, 1'b1); wait_done("mulxsu_pos", 0, 0, 0, 0);
  endtask

  task automatic test_zero();
    launch(2'b11, 32'd0, 32'h1234_5678, 1'b1); wait_done("zero_src1", 0, 0, 0, 0);
    launch(2'b00, 32'hCAFE_F00D, 32'd0, 1'b1); wait_done("zero_src2", 0, 0, 0, 0);
  endtask

  task automatic test_ignore_busy();
    int   dones;
    exp_t e;
    dones = 0;
    launch(2'b01, 32'h0001_0000, 32'h0001_0000, 1'b1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus_if.start = 1'b0;
      if (cyc == 2) bus_if.src1 = 32'h1234_0000;
      if (cyc == 3) begin
        bus_if.start = 1'b1;
        bus_if.op    = 2'b11;
        bus_if.src1  = 32'h7777_7777;
        bus_if.src2  = 32'h3333_3333;
      end
      if (cyc == 4) bus_if.start = 1'b0;
      if (bus_if.done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          e = sb_q.pop_front();
          n_cmp++;
          if (bus_if.result !== e.res || cyc != e.lat) begin
            n_err++;
            $display("FAIL ignore_busy done: got %h at %0d want %h at %0d", bus_if.result,
                     cyc, e.res, e.lat);
          end
        end
      end
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL ignore_busy count: got %0d dones want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    launch(2'b00, 32'h0000_1234, 32'h0000_5678, 1'b1);
    wait_done("b2b_first", 1, 2'b11, 32'hFFFF_FFF0, 32'h0000_0100);
    wait_done("b2b_second", 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    launch(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    @(posedge clk);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus_if.start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.result !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid state: got busy=%b done=%b result=%h want 0/0/0",
               bus_if.busy, bus_if.done, bus_if.result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus_if.done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0 || bus_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid after: got dones=%0d busy=%b want 0/0", dones, bus_if.busy);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 2'($urandom_range(3, 0));
      a  = $urandom();
      b  = (i % 4 == 3) ? 32'd0 : $urandom();
      launch(op, a, b, 1'b1);
      wait_done("random", 0, 0, 0, 0);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = 2'b00;
    bus_if.src1  = 32'd0;
    bus_if.src2  = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_mul_ops();
    test_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
